enigma_stream_core: RTL and testbench

ENIGMA_STREAM_CORE -- requirements
Module: enigma_stream_core

---
 rtl/enigma_stream_core.sv | 234 +++++++++++++++++++++++
 tb/tb_enigma_stream_core.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_stream_core.sv
// enigma_stream_core: streaming Enigma cipher. Stage 1 holds the accepted byte
// with its stepped rotor positions, stage 2 is a 2-entry output skid buffer that
// holds the enciphered result. Rotor positions can be reloaded in-band; the
// pipeline drains first so bytes in flight keep their old settings.
module enigma_stream_core #(
    parameter int                      NUM_ROTORS  = 3,
    parameter logic [3*NUM_ROTORS-1:0] ROTOR_TYPES = {3'd0, 3'd1, 3'd2},
    parameter logic [5*NUM_ROTORS-1:0] RING_POS    = '0,
    parameter logic                    REFLECTOR   = 1'b0,
    parameter logic [5*NUM_ROTORS-1:0] INIT_POS    = '0
) (
    input  logic                    i_clock,
    input  logic                    reset_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [7:0]              i_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [7:0]              o_data,
    input  logic                    cfg_load,
    input  logic [5*NUM_ROTORS-1:0] cfg_pos,
    output logic [5*NUM_ROTORS-1:0] o_pos,
    output logic                    o_busy,
    output logic [15:0]             o_count
);
    // Wirings as ASCII strings, leftmost character is the image of 'A'.
    localparam logic [207:0] WIRE_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    localparam logic [207:0] WIRE_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    localparam logic [207:0] WIRE_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    localparam logic [207:0] WIRE_IV  = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
    localparam logic [207:0] WIRE_V   = "VZBRGITYUPSDNHLXAWMOFCQKJE";
    localparam logic [207:0] REFL_B   = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    localparam logic [207:0] REFL_C   = "FVPJIAOYEDRZXWGCTKUQSBNMHL";

    typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_LOAD = 2'd2} state_t;

    function automatic logic [207:0] wire_of(input logic [2:0] t);
        case (t)
            3'd1:    return WIRE_II;
            3'd2:    return WIRE_III;
            3'd3:    return WIRE_IV;
            3'd4:    return WIRE_V;
            default: return WIRE_I;
        endcase
    endfunction

    function automatic logic [4:0] notch_of(input logic [2:0] t);
        case (t)
            3'd1:    return 5'd4;
            3'd2:    return 5'd21;
            3'd3:    return 5'd9;
            3'd4:    return 5'd25;
            default: return 5'd16;
        endcase
    endfunction

    function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
        return add26(a, 5'd26 - b);
    endfunction

    // Forward lookup: letter index -> wired letter index.
    function automatic logic [4:0] lut(input logic [207:0] w, input logic [4:0] i);
        logic [7:0] ch;
        ch = 8'd65;
        for (int k = 0; k < 26; k++)
            if (i == 5'(k)) ch = w[8*(25-k) +: 8];
        return 5'(ch - 8'd65);
    endfunction

    // Reverse lookup: find the contact that is wired to x.
    function automatic logic [4:0] inv_lut(input logic [207:0] w, input logic [4:0] x);
        logic [4:0] j;
        j = 5'd0;
        for (int k = 0; k < 26; k++)
            if (w[8*(25-k) +: 8] == 8'd65 + {3'b000, x}) j = 5'(k);
        return j;
    endfunction

    // Rotor offset is position minus ring setting, applied on entry and removed on exit.
    function automatic logic [4:0] rot_fwd(input logic [2:0] t, input logic [4:0] p,
                                           input logic [4:0] r, input logic [4:0] c);
        logic [4:0] sh;
        sh = sub26(p, r);
        return sub26(lut(wire_of(t), add26(c, sh)), sh);
    endfunction

    function automatic logic [4:0] rot_rev(input logic [2:0] t, input logic [4:0] p,
                                           input logic [4:0] r, input logic [4:0] c);
        logic [4:0] sh;
        sh = sub26(p, r);
        return sub26(inv_lut(wire_of(t), add26(c, sh)), sh);
    endfunction

    function automatic logic is_upper(input logic [7:0] b);
        return (b >= 8'd65) && (b <= 8'd90);
    endfunction

    function automatic logic is_lower(input logic [7:0] b);
        return (b >= 8'd97) && (b <= 8'd122);
    endfunction

    state_t                         state;
    logic                           rdy_en;
    logic [NUM_ROTORS-1:0][4:0]     pos, pos_step, cap_pos, load_pos;
    logic                           s1_vld;
    logic [7:0]                     s1_byte;
    logic [NUM_ROTORS-1:0][4:0]     s1_pos;
    logic [1:0][7:0]                fq;
    logic [1:0]                     fcnt;
    logic [7:0]                     enc_byte;
    logic [4:0]                     enc_c;
    logic                           in_xfer, out_xfer, s1_adv, pipe_empty, in_letter;

    assign in_letter  = is_upper(i_data) || is_lower(i_data);
    assign in_xfer    = i_valid && o_ready;
    assign out_xfer   = o_valid && i_ready;
    assign s1_adv     = s1_vld && ((fcnt != 2'd2) || out_xfer);
    assign pipe_empty = !s1_vld && (fcnt == 2'd0);
    // o_ready only looks at registered state, never at i_ready.
    assign o_ready    = rdy_en && (state == S_RUN) && !(s1_vld && (fcnt == 2'd2));
    assign o_valid    = (fcnt != 2'd0);
    assign o_data     = fq[0];
    assign o_busy     = (state != S_RUN);
    assign o_pos      = pos;

    // Odometer step with the middle-rotor double step; rotors above 2 stay put.
    always_comb begin
        pos_step    = pos;
        pos_step[0] = add26(pos[0], 5'd1);
        if (pos[0] == notch_of(ROTOR_TYPES[2:0]) || pos[1] == notch_of(ROTOR_TYPES[5:3]))
            pos_step[1] = add26(pos[1], 5'd1);
        if (pos[1] == notch_of(ROTOR_TYPES[5:3]))
            pos_step[2] = add26(pos[2], 5'd1);
    end

    // Out-of-range reload fields collapse to position 0.
    always_comb begin
        load_pos = cap_pos;
        for (int r = 0; r < NUM_ROTORS; r++)
            if (cap_pos[r] > 5'd25) load_pos[r] = 5'd0;
    end

    // Stage 2 cipher path: rotors forward, reflector, rotors back.
    always_comb begin
        enc_byte = s1_byte;
        enc_c    = 5'd0;
        if (is_upper(s1_byte) || is_lower(s1_byte)) begin
            enc_c = is_upper(s1_byte) ? 5'(s1_byte - 8'd65) : 5'(s1_byte - 8'd97);
            for (int r = 0; r < NUM_ROTORS; r++)
                enc_c = rot_fwd(ROTOR_TYPES[3*r +: 3], s1_pos[r], RING_POS[5*r +: 5], enc_c);
            enc_c = lut(REFLECTOR ? REFL_C : REFL_B, enc_c);
            for (int r = NUM_ROTORS - 1; r >= 0; r--)
                enc_c = rot_rev(ROTOR_TYPES[3*r +: 3], s1_pos[r], RING_POS[5*r +: 5], enc_c);
            enc_byte = (is_upper(s1_byte) ? 8'd65 : 8'd97) + {3'b000, enc_c};
        end
    end

    // Control FSM: rotor positions, letter count and the drain-then-load sequence.
    always_ff @(posedge i_clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_RUN;
            rdy_en  <= 1'b0;
            pos     <= INIT_POS;
            cap_pos <= '0;
            o_count <= '0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                S_RUN: begin
                    if (in_xfer && in_letter) begin
                        pos     <= pos_step;
                        o_count <= o_count + 16'd1;
                    end
                    if (cfg_load) begin
                        cap_pos <= cfg_pos;
                        state   <= (pipe_empty && !in_xfer) ? S_LOAD : S_DRAIN;
                    end
                end
                S_DRAIN: if (pipe_empty) state <= S_LOAD;
                S_LOAD: begin
                    pos     <= load_pos;
                    o_count <= '0;
                    state   <= S_RUN;
                end
                default: state <= S_RUN;
            endcase
        end
    end

    // Datapath: stage 1 register and the 2-entry output skid buffer (head in fq[0]).
    always_ff @(posedge i_clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld  <= 1'b0;
            s1_byte <= '0;
            s1_pos  <= '0;
            fq      <= '0;
            fcnt    <= '0;
        end else begin
            if (in_xfer) begin
                s1_vld  <= 1'b1;
                s1_byte <= i_data;
                s1_pos  <= pos_step;
            end else if (s1_adv) begin
                s1_vld <= 1'b0;
            end
            case ({s1_adv, out_xfer})
                2'b10: begin
                    if (fcnt == 2'd0) fq[0] <= enc_byte;
                    else              fq[1] <= enc_byte;
                    fcnt <= fcnt + 2'd1;
                end
                2'b01: begin
                    fq[0] <= fq[1];
                    fcnt  <= fcnt - 2'd1;
                end
                2'b11: begin
                    if (fcnt == 2'd1) fq[0] <= enc_byte;
                    else begin
                        fq[0] <= fq[1];
                        fq[1] <= enc_byte;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_enigma_stream_core.sv
// Bench for enigma_stream_core: directed phases with random bytes, checked
// against a string-table Enigma model (default rotors I-II-III, rings AAA, UKW-B).
module tb_enigma_stream_core;
    logic        i_clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic        cfg_load = 1'b0;
    logic [7:0]  i_data = 8'd0;
    logic [14:0] cfg_pos = 15'd0;
    logic        o_ready, o_valid, o_busy;
    logic [7:0]  o_data;
    logic [14:0] o_pos;
    logic [15:0] o_count;

    enigma_stream_core dut (
        .i_clock(i_clock), .reset_n(reset_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .cfg_load(cfg_load), .cfg_pos(cfg_pos), .o_pos(o_pos), .o_busy(o_busy),
        .o_count(o_count)
    );

    always #5 i_clock = ~i_clock;

    // ---------------- reference model ----------------
    string ROT[5] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                      "BDFHJLCPRTXVZNYEIWGAKMUSQO", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
                      "VZBRGITYUPSDNHLXAWMOFCQKJE"};
    string UKW_B = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    int    NOTCH[5] = '{16, 4, 21, 9, 25};
    int    TYPES[3] = '{2, 1, 0};   // rotor0 = III, rotor1 = II, rotor2 = I
    int    m_pos[3];
    int    m_count;

    logic [7:0] exp_q[$];
    logic [7:0] out_q[$];
    int         out_cyc_q[$];
    int         acc_cyc_q[$];

    function automatic int m26(int x);
        return ((x % 26) + 26) % 26;
    endfunction

    function automatic int rotor(int t, int p, int c, bit back);
        int x, y;
        x = m26(c + p);
        y = x;
        if (!back) y = int'(ROT[t][x]) - 65;
        else for (int j = 0; j < 26; j++) if (int'(ROT[t][j]) - 65 == x) y = j;
        return m26(y - p);
    endfunction

    function automatic bit letter(logic [7:0] b);
        return (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    function automatic logic [7:0] model_char(logic [7:0] b);
        int c, base;
        if (!letter(b)) return b;
        base = (b <= 8'h5A) ? 65 : 97;
        c = int'(b) - base;
        for (int r = 0; r < 3; r++) c = rotor(TYPES[r], m_pos[r], c, 1'b0);
        c = int'(UKW_B[c]) - 65;
        for (int r = 2; r >= 0; r--) c = rotor(TYPES[r], m_pos[r], c, 1'b1);
        return 8'(base + c);
    endfunction

    function automatic void model_accept(logic [7:0] b);
        bit n0, n1;
        if (letter(b)) begin
            n0 = (m_pos[0] == NOTCH[TYPES[0]]);
            n1 = (m_pos[1] == NOTCH[TYPES[1]]);
            m_pos[0] = m26(m_pos[0] + 1);
            if (n0 || n1) m_pos[1] = m26(m_pos[1] + 1);
            if (n1) m_pos[2] = m26(m_pos[2] + 1);
            m_count++;
        end
        exp_q.push_back(model_char(b));
    endfunction

    function automatic logic [14:0] packp(int p2, int p1, int p0);
        return 15'(p2 * 1024 + p1 * 32 + p0);
    endfunction

    // ---------------- checking helpers ----------------
    int n_asrt = 0;
    int n_fail = 0;
    int cyc = 0;
    int stall_left = 0;
    bit saw_nrdy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output bytes are captured between edges, when the transfer is already decided.
    always @(negedge i_clock)
        if (reset_n && o_valid && i_ready) begin
            out_q.push_back(o_data);
            out_cyc_q.push_back(cyc);
        end

    // One clock; inputs change 1 time unit after the edge. A stalled output must hold.
    task automatic tick();
        logic       hold;
        logic [7:0] held;
        hold = reset_n && o_valid && !i_ready;
        held = o_data;
        @(posedge i_clock);
        #1;
        cyc++;
        if (hold && reset_n) begin
            check("hold_valid", o_valid, 1);
            check("hold_data", o_data, held);
        end
        if (stall_left > 0) begin
            i_ready = 1'b0;
            stall_left--;
        end else i_ready = 1'b1;
        if (!o_ready) saw_nrdy = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        i_valid = 1'b1;
        i_data  = b;
        while (!o_ready && w < 40) begin
            tick();
            w++;
        end
        check("send_bound", w >= 40, 0);
        tick();
        model_accept(b);
        acc_cyc_q.push_back(cyc);
        i_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input string lit, input bit chk_lat);
        int w;
        w = 0;
        while ((out_q.size() < exp_q.size() || o_valid) && w < 200) begin
            tick();
            w++;
        end
        check({tag, "_bound"}, w >= 200, 0);
        check({tag, "_n"}, out_q.size(), exp_q.size());
        for (int i = 0; i < lit.len() && i < out_q.size(); i++)
            check({tag, "_lit"}, out_q[i], lit[i]);
        if (chk_lat)
            for (int i = 0; i < out_cyc_q.size() && i < acc_cyc_q.size(); i++)
                check({tag, "_lat"}, out_cyc_q[i] - acc_cyc_q[i], 1);
        while (out_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_d"}, out_q.pop_front(), exp_q.pop_front());
        out_q.delete();
        exp_q.delete();
        out_cyc_q.delete();
        acc_cyc_q.delete();
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 3))
            0, 1:    return 8'($urandom_range(65, 90));
            2:       return 8'($urandom_range(97, 122));
            default: return 8'($urandom_range(32, 64));
        endcase
    endfunction

    initial begin
        int c0;
        m_pos = '{0, 0, 0};
        m_count = 0;

        // Reset state, asserted from time 0.
        #2;
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_count", o_count, 0);
        check("rst_busy", o_busy, 0);
        check("rst_pos", o_pos, 0);
        #10 reset_n = 1'b1;
        tick();
        check("rst_ready", o_ready, 1);

        // "AAAAA" from AAA gives "BDZGO"; output follows on the edge after acceptance.
        for (int i = 0; i < 5; i++) send(8'h41);
        drain("aaaaa", "BDZGO", 1'b1);
        check("aaaaa_count", o_count, 5);
        check("aaaaa_rotor0", o_pos[4:0], 5);
        check("aaaaa_pos", o_pos, packp(m_pos[2], m_pos[1], m_pos[0]));

        // Load ADU with an empty pipeline, then watch the double step.
        cfg_pos  = packp(0, 3, 20);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        check("load_busy", o_busy, 1);
        check("load_ready", o_ready, 0);
        tick();
        check("load_done_busy", o_busy, 0);
        check("load_pos", o_pos, packp(0, 3, 20));
        check("load_count", o_count, 0);
        m_pos = '{20, 3, 0};
        m_count = 0;
        send(8'h41);
        check("step_ADV", o_pos, packp(0, 3, 21));
        send(8'h41);
        check("step_AEW", o_pos, packp(0, 4, 22));
        send(8'h41);
        check("step_BFX", o_pos, packp(1, 5, 23));
        drain("adu", "", 1'b1);

        // Non-letters pass through without stepping or counting.
        c0 = m_count;
        send(8'h41); send(8'h20); send(8'h61); send(8'h21);
        drain("pass", "", 1'b0);
        check("pass_count", o_count, c0 + 2);
        check("pass_pos", o_pos, packp(m_pos[2], m_pos[1], m_pos[0]));

        // Random stream with a 5-cycle downstream stall in the middle.
        saw_nrdy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) stall_left = 5;
            send(rand_byte());
        end
        check("stall_ready_drop", saw_nrdy, 1);
        drain("stall", "", 1'b0);
        check("stall_count", o_count, m_count);
        check("stall_pos", o_pos, packp(m_pos[2], m_pos[1], m_pos[0]));

        // Load with two bytes in flight; the second is accepted on the load cycle.
        i_ready = 1'b0;
        stall_left = 1000;
        send(rand_byte() | 8'h40 & 8'h5F | 8'h41);
        cfg_pos  = packp(12, 30, 7);
        cfg_load = 1'b1;
        send(8'h5A);
        cfg_load = 1'b0;
        check("drain_busy", o_busy, 1);
        check("drain_ready", o_ready, 0);
        cfg_pos  = packp(1, 1, 1);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        tick();
        stall_left = 0;
        drain("drain", "", 1'b0);
        tick(); tick(); tick();
        check("reload_busy", o_busy, 0);
        check("reload_pos", o_pos, packp(12, 0, 7));
        check("reload_count", o_count, 0);
        m_pos = '{7, 0, 12};
        m_count = 0;

        // Reset with three bytes in flight: everything is discarded.
        i_ready = 1'b0;
        stall_left = 1000;
        for (int i = 0; i < 3; i++) send(8'($urandom_range(65, 90)));
        check("full_ready", o_ready, 0);
        check("full_valid", o_valid, 1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_data", o_data, 0);
        check("mid_rst_pos", o_pos, 0);
        check("mid_rst_count", o_count, 0);
        check("mid_rst_busy", o_busy, 0);
        exp_q.delete();
        acc_cyc_q.delete();
        m_pos = '{0, 0, 0};
        m_count = 0;
        stall_left = 0;
        i_ready = 1'b1;
        tick();
        #2 reset_n = 1'b1;
        tick();
        check("post_rst_ready", o_ready, 1);
        tick(); tick(); tick();
        check("post_rst_no_out", out_q.size(), 0);
        for (int i = 0; i < 6; i++) send(rand_byte());
        drain("post", "", 1'b1);
        check("post_count", o_count, m_count);
        check("post_pos", o_pos, packp(m_pos[2], m_pos[1], m_pos[0]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
